// File: rtl/addr_gen_mc.sv
// Multi-channel operand address generator: N_BASES strided/circular base counters,
// a series counter and a two-stage address pipeline (base + offset, then + series).
module addr_gen_mc #(
  parameter int ADDR_WIDTH = 9,
  parameter int N_BASES    = 4,
  parameter int OFF_WIDTH  = 4,
  parameter logic [N_BASES*ADDR_WIDTH-1:0] BASE_START = '0,
  parameter logic [N_BASES*ADDR_WIDTH-1:0] BASE_INC   = {N_BASES{ADDR_WIDTH'(1)}},
  parameter logic [N_BASES*ADDR_WIDTH-1:0] BASE_LEN   = '0,
  parameter logic [ADDR_WIDTH-1:0]         SERIES_INC = '0,
  localparam int SEL_W = (N_BASES > 1) ? $clog2(N_BASES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BASES-1:0]         base_inc,
  input  logic [N_BASES-1:0]         base_rst,
  input  logic [SEL_W+OFF_WIDTH-1:0] addr_ptr,
  input  logic                       ptr_valid,
  input  logic                       series_inc,
  input  logic                       series_rst,
  output logic [ADDR_WIDTH-1:0]      addr_out,
  output logic                       addr_valid
);

  // Advance one base by its stride; a non-zero length folds the result back
  // into [start, start+len). The compare is done one bit wider so a range
  // touching the top of the address space still wraps correctly.
  function automatic logic [ADDR_WIDTH-1:0] advance(
    input logic [ADDR_WIDTH-1:0] cur,
    input logic [ADDR_WIDTH-1:0] inc,
    input logic [ADDR_WIDTH-1:0] start,
    input logic [ADDR_WIDTH-1:0] len
  );
    logic [ADDR_WIDTH:0] nxt;
    logic [ADDR_WIDTH:0] lim;
    logic [ADDR_WIDTH:0] folded;
    nxt    = {1'b0, cur} + {1'b0, inc};
    lim    = {1'b0, start} + {1'b0, len};
    folded = nxt - {1'b0, len};
    if (len == '0)
      return nxt[ADDR_WIDTH-1:0];
    else if (nxt >= lim)
      return folded[ADDR_WIDTH-1:0];
    else
      return nxt[ADDR_WIDTH-1:0];
  endfunction

  logic [N_BASES*ADDR_WIDTH-1:0] cnt_flat;
  logic [ADDR_WIDTH-1:0]         series_r;
  logic [SEL_W-1:0]              sel;
  logic [OFF_WIDTH-1:0]          off;
  logic [ADDR_WIDTH-1:0]         base_sel;

  assign {sel, off} = addr_ptr;

  for (genvar g = 0; g < N_BASES; g++) begin : g_base
    localparam logic [ADDR_WIDTH-1:0] START = BASE_START[g*ADDR_WIDTH +: ADDR_WIDTH];
    localparam logic [ADDR_WIDTH-1:0] INC   = BASE_INC[g*ADDR_WIDTH +: ADDR_WIDTH];
    localparam logic [ADDR_WIDTH-1:0] LEN   = BASE_LEN[g*ADDR_WIDTH +: ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= START;
      else if (base_rst[g])
        cnt_q <= START;
      else if (base_inc[g])
        cnt_q <= advance(cnt_q, INC, START, LEN);
    end

    assign cnt_flat[g*ADDR_WIDTH +: ADDR_WIDTH] = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      series_r <= '0;
    else if (series_rst)
      series_r <= '0;
    else if (series_inc)
      series_r <= series_r + SERIES_INC;
  end

  // Out-of-range selects fall through to base 0.
  always_comb begin
    base_sel = cnt_flat[ADDR_WIDTH-1:0];
    for (int i = 1; i < N_BASES; i++) begin
      if (sel == SEL_W'(i))
        base_sel = cnt_flat[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Stage 1: base + offset, using counter values from before this edge
  logic [ADDR_WIDTH-1:0] sum_p1;
  logic                  vld_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      sum_p1 <= base_sel + ADDR_WIDTH'(off);
      vld_p1 <= ptr_valid;
    end
  end

  // Stage 2: add the series offset current at this edge
  logic [ADDR_WIDTH-1:0] addr_p2;
  logic                  vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      addr_p2 <= sum_p1 + series_r;
      vld_p2  <= vld_p1;
    end
  end

  assign addr_out   = addr_p2;
  assign addr_valid = vld_p2;

endmodule

// File: tb/tb_addr_gen_mc.sv
// Scoreboard bench for addr_gen_mc: directed scenarios plus random traffic,
// expected addresses from an arithmetic model queued at issue time.
module tb_addr_gen_mc;
  localparam int AW = 9;
  localparam int NB = 5;
  localparam int OW = 4;
  localparam int SW = 3;

  localparam logic [NB*AW-1:0] P_START = {9'd0, 9'd510, 9'd0, 9'd100, 9'd0};
  localparam logic [NB*AW-1:0] P_INC   = {9'd1, 9'd3,   9'd1, 9'd4,   9'd1};
  localparam logic [NB*AW-1:0] P_LEN   = {9'd0, 9'd0,   9'd0, 9'd12,  9'd0};

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     base_inc;
  logic [NB-1:0]     base_rst;
  logic [SW+OW-1:0]  addr_ptr;
  logic              ptr_valid;
  logic              series_inc;
  logic              series_rst;
  logic [AW-1:0]     addr_out;
  logic              addr_valid;

  addr_gen_mc #(
    .ADDR_WIDTH(AW), .N_BASES(NB), .OFF_WIDTH(OW),
    .BASE_START(P_START), .BASE_INC(P_INC), .BASE_LEN(P_LEN),
    .SERIES_INC(9'd32)
  ) dut (
    .clk(clk), .rst(rst), .base_inc(base_inc), .base_rst(base_rst),
    .addr_ptr(addr_ptr), .ptr_valid(ptr_valid), .series_inc(series_inc),
    .series_rst(series_rst), .addr_out(addr_out), .addr_valid(addr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit has_k;
    int k;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: plain integers, circular bases advance modulo their length.
  int m_start[NB] = '{0, 100, 0, 510, 0};
  int m_inc[NB]   = '{1, 4, 1, 3, 1};
  int m_len[NB]   = '{0, 12, 0, 0, 0};
  int m_cnt[NB];
  int m_ser;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_cnt[i] = m_start[i];
    m_ser = 0;
  endtask

  task automatic drive(input logic [NB-1:0] bi, input logic [NB-1:0] br,
                       input int sel, input int off, input bit pv,
                       input bit si, input bit sr,
                       input bit has_k = 1'b0, input int k = 0);
    int s;
    int nser;
    exp_t e;
    @(negedge clk);
    base_inc   = bi;
    base_rst   = br;
    addr_ptr   = {SW'(sel), OW'(off)};
    ptr_valid  = pv;
    series_inc = si;
    series_rst = sr;
    s    = (sel < NB) ? sel : 0;
    nser = sr ? 0 : (si ? (m_ser + 32) % 512 : m_ser);
    e.addr  = (m_cnt[s] + off + nser) % 512;
    e.has_k = has_k;
    e.k     = k;
    for (int i = 0; i < NB; i++) begin
      if (br[i])
        m_cnt[i] = m_start[i];
      else if (bi[i]) begin
        if (m_len[i] == 0)
          m_cnt[i] = (m_cnt[i] + m_inc[i]) % 512;
        else
          m_cnt[i] = m_start[i] + (m_cnt[i] - m_start[i] + m_inc[i]) % m_len[i];
      end
    end
    m_ser = nser;
    if (pv) q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: every valid output pops one expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && addr_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got addr_out=%0d with valid, expected no output", addr_out);
        end else begin
          e_mon = q.pop_front();
          check("model_addr", int'(addr_out), e_mon.addr);
          if (e_mon.has_k) check("directed_addr", int'(addr_out), e_mon.k);
        end
      end
    end
  end

  initial begin
    logic [NB-1:0] rb;
    rst = 1'b1;
    base_inc = '0; base_rst = '0; addr_ptr = '0; ptr_valid = 1'b0;
    series_inc = 1'b0; series_rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr_out", int'(addr_out), 0);
    check("reset_addr_valid", int'(addr_valid), 0);
    rst = 1'b0;

    // First pointer after reset
    drive('0, '0, 2, 3, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    idle(2);

    // Circular base 1: start 100, stride 4, length 12
    drive(5'b00010, '0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 100);
    drive(5'b00010, '0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 104);
    drive(5'b00010, '0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 108);
    drive(5'b00010, '0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 100);
    drive('0,       '0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 104);

    // Reload beats increment; same-cycle pointer sees old count
    for (int i = 0; i < 7; i++) drive(5'b00001, '0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(5'b00001, 5'b00001, 0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 9);
    drive('0, '0, 0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 2);

    // Free-running overflow on base 3 and out-of-range select aliasing
    drive(5'b01000, '0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive('0, '0, 3, 15, 1'b1, 1'b0, 1'b0, 1'b1, 16);
    drive('0, '0, 5, 4,  1'b1, 1'b0, 1'b0, 1'b1, 4);
    drive('0, '0, 7, 1,  1'b1, 1'b0, 1'b0, 1'b1, 1);

    // Series counter and its reset priority
    drive('0, '0, 0, 0, 1'b0, 1'b1, 1'b0);
    drive('0, '0, 0, 0, 1'b0, 1'b1, 1'b0);
    drive('0, '0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 65);
    drive('0, '0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    idle(3);

    // Async reset between two valid pointers
    drive(5'b00010, '0, 1, 0, 1'b1, 1'b0, 1'b0);
    drive('0, '0, 1, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_valid_drop", int'(addr_valid), 0);
    check("midreset_addr_out", int'(addr_out), 0);
    q.delete();
    model_reset();
    base_inc = '0; base_rst = '0; addr_ptr = '0; ptr_valid = 1'b0;
    series_inc = 1'b0; series_rst = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive('0, '0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 100);
    idle(3);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NB; b++) rb[b] = ($urandom_range(0, 7) == 0);
      drive(NB'($urandom), rb, $urandom_range(0, 7), $urandom_range(0, 15),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end
    idle(4);
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
